// File: rtl/johnson_phase_decoder.sv
// johnson_phase_decoder: samples a fill-from-LSB Johnson code each enabled clock.
// It decodes the code to a one-hot phase and a binary phase index, checks that
// each code is legal and follows its predecessor, runs an UNLOCK/ACQUIRE/LOCKED
// state machine, and counts completed Johnson cycles while locked.
// Optional feature: define JPD_ERR_COUNT_EN to build a saturating 8-bit
// error-event counter. Without it, err_count is tied to 0.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   en           sample enable; all state holds when low
//   count_in     WIDTH-bit Johnson code from the counter
//   clr_err      synchronous clear of the sticky error flags
//   phase_onehot one-hot phase, zero on an illegal sample
//   phase_idx    binary phase index, holds on an illegal sample
//   locked       high while in LOCKED
//   cycle_count  completed cycles counted while locked, wraps
//   cycle_pulse  one-cycle strobe per counted cycle
//   err_illegal  sticky illegal-code flag
//   err_seq      sticky out-of-sequence flag
//   err_count    saturating error-event count
module johnson_phase_decoder #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned LOCK_N = 2,
  parameter int unsigned CYC_W  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [WIDTH-1:0]              count_in,
  input  logic                          clr_err,
  output logic [2*WIDTH-1:0]            phase_onehot,
  output logic [$clog2(2*WIDTH)-1:0]    phase_idx,
  output logic                          locked,
  output logic [CYC_W-1:0]              cycle_count,
  output logic                          cycle_pulse,
  output logic                          err_illegal,
  output logic                          err_seq,
  output logic [7:0]                    err_count
);

  localparam int unsigned N     = 2 * WIDTH;
  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned ACQ_W = $clog2(LOCK_N + 1);

  typedef enum logic [1:0] {
    ST_UNLOCK  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ACQ_W-1:0]   acq_q, acq_d;
  logic [N-1:0]       onehot_q, onehot_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               locked_q, locked_d;
  logic [CYC_W-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic               pulse_q, pulse_d;
  logic               err_ill_q, err_ill_d;
  logic               err_seq_q, err_seq_d;

  logic               legal_c;
  logic [IDX_W-1:0]   idx_c;
  logic [IDX_W-1:0]   succ_idx_c;
  logic               is_succ_c;
  logic               ill_evt_c;
  logic               seq_evt_c;
  logic               wrap_c;

  // Legal code for phase k: k LSBs set up to WIDTH, then LSBs clear from the bottom.
  function automatic logic [WIDTH-1:0] jcode(input int unsigned k);
    logic [WIDTH-1:0] c;
    c = '0;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      if (k <= WIDTH) c[b] = (b < k);
      else            c[b] = (b >= (k - WIDTH));
    end
    return c;
  endfunction

  // Decode the sample to a phase index.
  always_comb begin
    legal_c = 1'b0;
    idx_c   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (count_in == jcode(k)) begin
        legal_c = 1'b1;
        idx_c   = IDX_W'(k);
      end
    end
  end

  // idx_q always holds the last legal index, so it serves as the predecessor.
  assign succ_idx_c = (idx_q == IDX_W'(N - 1)) ? '0 : IDX_W'(idx_q + 1'b1);
  assign is_succ_c  = legal_c && (idx_c == succ_idx_c);
  assign wrap_c     = is_succ_c && (idx_q == IDX_W'(N - 1));

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    acq_d     = acq_q;
    onehot_d  = onehot_q;
    idx_d     = idx_q;
    cyc_cnt_d = cyc_cnt_q;
    pulse_d   = 1'b0;
    ill_evt_c = 1'b0;
    seq_evt_c = 1'b0;
    err_ill_d = err_ill_q;
    err_seq_d = err_seq_q;

    if (en) begin
      if (legal_c) begin
        idx_d    = idx_c;
        onehot_d = N'(1) << idx_c;
      end else begin
        onehot_d = '0;
      end

      unique case (state_q)
        ST_UNLOCK: begin
          if (legal_c) begin
            state_d = ST_ACQUIRE;
            acq_d   = '0;
          end else begin
            ill_evt_c = 1'b1;
          end
        end
        ST_ACQUIRE: begin
          if (!legal_c) begin
            state_d   = ST_UNLOCK;
            acq_d     = '0;
            ill_evt_c = 1'b1;
          end else if (is_succ_c) begin
            acq_d = ACQ_W'(acq_q + 1'b1);
            if (ACQ_W'(acq_q + 1'b1) == ACQ_W'(LOCK_N)) state_d = ST_LOCKED;
          end else begin
            acq_d     = '0;
            seq_evt_c = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!legal_c) begin
            state_d   = ST_UNLOCK;
            acq_d     = '0;
            ill_evt_c = 1'b1;
          end else if (is_succ_c) begin
            if (wrap_c) begin
              cyc_cnt_d = CYC_W'(cyc_cnt_q + 1'b1);
              pulse_d   = 1'b1;
            end
          end else begin
            state_d   = ST_ACQUIRE;
            acq_d     = '0;
            seq_evt_c = 1'b1;
          end
        end
        default: begin
          state_d = ST_UNLOCK;
          acq_d   = '0;
        end
      endcase

      // A fresh error wins over a simultaneous clear.
      err_ill_d = (err_ill_q & ~clr_err) | ill_evt_c;
      err_seq_d = (err_seq_q & ~clr_err) | seq_evt_c;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_UNLOCK;
      acq_q     <= '0;
      onehot_q  <= '0;
      idx_q     <= '0;
      locked_q  <= 1'b0;
      cyc_cnt_q <= '0;
      pulse_q   <= 1'b0;
      err_ill_q <= 1'b0;
      err_seq_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acq_q     <= acq_d;
      onehot_q  <= onehot_d;
      idx_q     <= idx_d;
      locked_q  <= locked_d;
      cyc_cnt_q <= cyc_cnt_d;
      pulse_q   <= pulse_d;
      err_ill_q <= err_ill_d;
      err_seq_q <= err_seq_d;
    end
  end

`ifdef JPD_ERR_COUNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // One increment per erroring edge, saturating; only reset clears it.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((ill_evt_c || seq_evt_c) && (err_cnt_q != 8'hFF)) err_cnt_d = 8'(err_cnt_q + 1'b1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

  assign phase_onehot = onehot_q;
  assign phase_idx    = idx_q;
  assign locked       = locked_q;
  assign cycle_count  = cyc_cnt_q;
  assign cycle_pulse  = pulse_q;
  assign err_illegal  = err_ill_q;
  assign err_seq      = err_seq_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed testbench for johnson_phase_decoder (WIDTH=4, LOCK_N=2, CYC_W=8).
module tb_johnson_phase_decoder;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] count_in;
  logic       clr_err;
  logic [7:0] phase_onehot;
  logic [2:0] phase_idx;
  logic       locked;
  logic [7:0] cycle_count;
  logic       cycle_pulse;
  logic       err_illegal;
  logic       err_seq;
  logic [7:0] err_count;

  int n_tests;
  int n_fail;

  // Counter model: standard Johnson shift with inverted MSB fed into the LSB.
  logic [3:0] code;
  int         idx;

`ifdef JPD_ERR_COUNT_EN
  localparam bit ECE = 1'b1;
`else
  localparam bit ECE = 1'b0;
`endif

  johnson_phase_decoder #(.WIDTH(4), .LOCK_N(2), .CYC_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .count_in    (count_in),
    .clr_err     (clr_err),
    .phase_onehot(phase_onehot),
    .phase_idx   (phase_idx),
    .locked      (locked),
    .cycle_count (cycle_count),
    .cycle_pulse (cycle_pulse),
    .err_illegal (err_illegal),
    .err_seq     (err_seq),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic advance();
    code = {code[2:0], ~code[3]};
    idx  = (idx + 1) % 8;
  endtask

  function automatic logic [7:0] exp_ec(input int n);
    return ECE ? 8'(n) : 8'd0;
  endfunction

  task automatic test_reset();
    en = 1'b0; clr_err = 1'b0; count_in = 4'b0000;
    reset = 1'b0;
    #12;
    n_tests++;
    if ({phase_onehot, phase_idx, locked, cycle_count, cycle_pulse, err_illegal, err_seq, err_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: onehot=%b idx=%0d locked=%b cnt=%0d pulse=%b ei=%b es=%b ec=%0d required all 0",
               phase_onehot, phase_idx, locked, cycle_count, cycle_pulse, err_illegal, err_seq, err_count);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_lock();
    logic [7:0] eoh;
    code = 4'b0000; idx = 0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      count_in = code;
      step();
      eoh = 8'd1 << i;
      n_tests++;
      if (phase_idx !== 3'(i) || phase_onehot !== eoh) begin
        n_fail++;
        $display("FAIL lock_decode[%0d]: idx=%0d onehot=%b required idx=%0d onehot=%b", i, phase_idx, phase_onehot, i, eoh);
      end
      n_tests++;
      if (locked !== (i == 2)) begin
        n_fail++;
        $display("FAIL lock_latency[%0d]: locked=%b required %b", i, locked, (i == 2));
      end
      advance();
    end
    n_tests++;
    if (err_illegal !== 1'b0 || err_seq !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_no_err: ei=%b es=%b required 0 0", err_illegal, err_seq);
    end
  endtask

  task automatic test_cycle_count();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      count_in = code;
      step();
      if (cycle_pulse === 1'b1) pulses++;
      n_tests++;
      if (cycle_pulse !== (idx == 0) || locked !== 1'b1) begin
        n_fail++;
        $display("FAIL cycle_pulse[%0d]: pulse=%b locked=%b required pulse=%b locked=1", i, cycle_pulse, locked, (idx == 0));
      end
      advance();
    end
    n_tests++;
    if (cycle_count !== 8'd3 || pulses != 3) begin
      n_fail++;
      $display("FAIL cycle_count: count=%0d pulses=%0d required 3 3", cycle_count, pulses);
    end
  endtask

  task automatic test_illegal();
    count_in = 4'b0101;
    step();
    n_tests++;
    if (phase_onehot !== 8'd0 || phase_idx !== 3'd2 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_decode: onehot=%b idx=%0d locked=%b required 0 2 0", phase_onehot, phase_idx, locked);
    end
    n_tests++;
    if (err_illegal !== 1'b1 || err_seq !== 1'b0 || err_count !== exp_ec(1)) begin
      n_fail++;
      $display("FAIL illegal_flags: ei=%b es=%b ec=%0d required 1 0 %0d", err_illegal, err_seq, err_count, exp_ec(1));
    end
    // From UNLOCK a full 3-sample acquisition is needed again.
    code = 4'b0000; idx = 0;
    for (int i = 0; i < 3; i++) begin
      count_in = code;
      step();
      n_tests++;
      if (locked !== (i == 2) || phase_idx !== 3'(i)) begin
        n_fail++;
        $display("FAIL illegal_relock[%0d]: locked=%b idx=%0d required %b %0d", i, locked, phase_idx, (i == 2), i);
      end
      advance();
    end
  endtask

  task automatic test_skip();
    for (int i = 0; i < 6; i++) begin
      count_in = code;
      step();
      advance();
    end
    n_tests++;
    if (locked !== 1'b1 || phase_idx !== 3'd0 || cycle_count !== 8'd4) begin
      n_fail++;
      $display("FAIL skip_pre: locked=%b idx=%0d cnt=%0d required 1 0 4", locked, phase_idx, cycle_count);
    end
    count_in = 4'b0011;
    step();
    n_tests++;
    if (err_seq !== 1'b1 || locked !== 1'b0 || phase_idx !== 3'd2 || phase_onehot !== 8'b0000_0100 ||
        err_count !== exp_ec(2)) begin
      n_fail++;
      $display("FAIL skip_detect: es=%b locked=%b idx=%0d onehot=%b ec=%0d required 1 0 2 00000100 %0d",
               err_seq, locked, phase_idx, phase_onehot, err_count, exp_ec(2));
    end
    code = 4'b0111; idx = 3;
    count_in = code;
    step();
    n_tests++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL skip_relock1: locked=%b required 0", locked);
    end
    advance();
    count_in = code;
    step();
    n_tests++;
    if (locked !== 1'b1 || phase_idx !== 3'd4) begin
      n_fail++;
      $display("FAIL skip_relock2: locked=%b idx=%0d required 1 4", locked, phase_idx);
    end
    advance();
  endtask

  task automatic test_hold_and_clear();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      count_in = (i % 2 == 0) ? 4'b0101 : code;
      step();
      n_tests++;
      if (phase_idx !== 3'd4 || phase_onehot !== 8'b0001_0000 || locked !== 1'b1 || cycle_count !== 8'd4 ||
          cycle_pulse !== 1'b0 || err_illegal !== 1'b1 || err_seq !== 1'b1 || err_count !== exp_ec(2)) begin
        n_fail++;
        $display("FAIL hold[%0d]: idx=%0d onehot=%b locked=%b cnt=%0d pulse=%b ei=%b es=%b ec=%0d required 4 00010000 1 4 0 1 1 %0d",
                 i, phase_idx, phase_onehot, locked, cycle_count, cycle_pulse, err_illegal, err_seq, err_count, exp_ec(2));
      end
    end
    en = 1'b1;
    clr_err = 1'b1;
    count_in = 4'b0101;
    step();
    n_tests++;
    if (err_illegal !== 1'b1 || err_seq !== 1'b0 || locked !== 1'b0 || phase_onehot !== 8'd0 ||
        err_count !== exp_ec(3)) begin
      n_fail++;
      $display("FAIL clr_vs_err: ei=%b es=%b locked=%b onehot=%b ec=%0d required 1 0 0 0 %0d",
               err_illegal, err_seq, locked, phase_onehot, err_count, exp_ec(3));
    end
    count_in = 4'b0000;
    step();
    clr_err = 1'b0;
    n_tests++;
    if (err_illegal !== 1'b0 || err_seq !== 1'b0 || phase_idx !== 3'd0 || err_count !== exp_ec(3)) begin
      n_fail++;
      $display("FAIL clr_only: ei=%b es=%b idx=%0d ec=%0d required 0 0 0 %0d",
               err_illegal, err_seq, phase_idx, err_count, exp_ec(3));
    end
  endtask

  task automatic test_async_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    code = 4'b0000; idx = 0;
    for (int i = 0; i < 41; i++) begin
      count_in = code;
      step();
      advance();
    end
    n_tests++;
    if (locked !== 1'b1 || cycle_count !== 8'd5 || phase_idx !== 3'd0 || err_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL async_pre: locked=%b cnt=%0d idx=%0d ei=%b required 1 5 0 0", locked, cycle_count, phase_idx, err_illegal);
    end
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if ({phase_onehot, phase_idx, locked, cycle_count, cycle_pulse, err_illegal, err_seq, err_count} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: onehot=%b idx=%0d locked=%b cnt=%0d pulse=%b ei=%b es=%b ec=%0d required all 0",
               phase_onehot, phase_idx, locked, cycle_count, cycle_pulse, err_illegal, err_seq, err_count);
    end
    #2;
    reset = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    code    = 4'b0000;
    idx     = 0;
    test_reset();
    test_lock();
    test_cycle_count();
    test_illegal();
    test_skip();
    test_hold_and_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
